// File: rtl/uart_pkg.sv
// Shared types and helpers for the byte-stream UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic        UART_IDLE_LVL  = 1'b1;
  localparam int unsigned UART_DATA_BITS = 8;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte push handshake between the register-dump formatter and the UART transmitter.
interface uart_tx_fifo_if;
  import uart_pkg::*;

  logic                      tx_valid;
  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an explicit occupancy counter; push and pop may share an edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW + 1)'(DEPTH));
  assign empty   = (level == '0);
  // A pop frees the head slot on the same edge, so a full FIFO may still accept.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; only pointers and count are, so it can map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO; frames are sent back-to-back while data is queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 27_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  uart_tx_fifo_if.slave                 tx_if,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned DIV   = uart_div(CLK_HZ, BAUD);
  localparam int unsigned CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_tx_fifo: baud divisor must be at least 2");
  end

  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_rdata;

  assign tx_if.tx_ready = !fifo_full;
  assign fifo_push      = tx_if.tx_valid && !fifo_full;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (tx_if.tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  tx_state_t                 state, state_next;
  logic [CNT_W-1:0]          baud_cnt, cnt_next;
  logic [IDX_W-1:0]          bit_idx, idx_next;
  logic [UART_DATA_BITS-1:0] shift, shift_next;
  logic                      tx_next;
  logic                      bit_end;

  assign bit_end = (baud_cnt == CNT_LAST);

  // NOTE: every signal gets a default before the case, so no path leaves one unassigned (no latches).
  always_comb begin
    state_next = state;
    cnt_next   = (state == IDLE || bit_end) ? '0 : baud_cnt + CNT_W'(1);
    idx_next   = bit_idx;
    shift_next = shift;
    fifo_pop   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_rdata;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          idx_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift >> 1;
          if (bit_idx == IDX_LAST) state_next = STOP;
          else                     idx_next   = bit_idx + IDX_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_rdata;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is derived from the next state so uart_tx comes straight from a flop.
    unique case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = UART_IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      uart_tx  <= UART_IDLE_LVL;
    end else begin
      state    <= state_next;
      baud_cnt <= cnt_next;
      bit_idx  <= idx_next;
      shift    <= shift_next;
      uart_tx  <= tx_next;
    end
  end

  assign busy = (state != IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: pushed bytes are queued as expectations, a bench UART receiver decodes and compares.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_fifo_if a_if ();
  uart_tx_fifo_if b_if ();
  uart_tx_fifo_if c_if ();

  logic       a_tx, b_tx, c_tx;
  logic       a_busy, b_busy, c_busy;
  logic [4:0] a_lvl, c_lvl;
  logic [2:0] b_lvl;

  uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .tx_if(a_if), .uart_tx(a_tx), .busy(a_busy), .fifo_level(a_lvl));
  uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .tx_if(b_if), .uart_tx(b_tx), .busy(b_busy), .fifo_level(b_lvl));
  uart_tx_fifo u_dut_c (
    .clk(clk), .rst_n(rst_n), .tx_if(c_if), .uart_tx(c_tx), .busy(c_busy), .fifo_level(c_lvl));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int sel   = 0;
  int mon_div = 10;

  logic       line, sel_busy, sel_ready;
  logic [4:0] sel_lvl;
  assign line      = (sel == 0) ? a_tx : (sel == 1) ? b_tx : c_tx;
  assign sel_busy  = (sel == 0) ? a_busy : (sel == 1) ? b_busy : c_busy;
  assign sel_ready = (sel == 0) ? a_if.tx_ready : (sel == 1) ? b_if.tx_ready : c_if.tx_ready;
  assign sel_lvl   = (sel == 0) ? a_lvl : (sel == 1) ? {2'b00, b_lvl} : c_lvl;

  logic [7:0] exp_q[$];
  logic [7:0] stim_q[$];
  logic [4:0] lvl_after[$];

  // receiver / monitor state
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;
  int         rx_k;
  logic [7:0] rx_shift;
  logic [7:0] rx_exp;
  bit         mark_first = 1'b0;
  bit         gap_chk = 1'b0;
  bit         have_prev = 1'b0;
  int         first_start = 0;
  int         prev_start = 0;
  int         last_end = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic select(input int s, input int d);
    sel     = s;
    mon_div = d;
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    case (sel)
      0:       begin a_if.tx_valid = v; a_if.tx_data = d; end
      1:       begin b_if.tx_valid = v; b_if.tx_data = d; end
      default: begin c_if.tx_valid = v; c_if.tx_data = d; end
    endcase
  endtask

  // Holds tx_valid across stim_q; records stalls, ready runs after first full and level after each push.
  task automatic send(input bit expect_en, input int depth, output int stalls, output int max_run);
    int  run;
    int  budget;
    bit  seen_full;
    stalls    = 0;
    max_run   = 0;
    run       = 0;
    seen_full = 1'b0;
    lvl_after.delete();
    for (int i = 0; i < stim_q.size(); i++) begin
      drive(1'b1, stim_q[i]);
      budget = 0;
      while (!sel_ready) begin
        stalls++;
        run = 0;
        @(posedge clk); #1;
        budget++;
        if (budget > 5000) begin
          check("send_ready_timeout", 32'd1, 32'd0);
          drive(1'b0, 8'h00);
          return;
        end
      end
      if (seen_full) begin
        run++;
        if (run > max_run) max_run = run;
      end
      if (expect_en) exp_q.push_back(stim_q[i]);
      @(posedge clk); #1;
      lvl_after.push_back(sel_lvl);
      if (int'(sel_lvl) == depth) seen_full = 1'b1;
    end
    drive(1'b0, 8'h00);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sel_busy || rx_active || exp_q.size() != 0) && n < budget);
    check({name, "_done_in_time"}, 32'(n < budget), 32'd1);
    check({name, "_drained"}, exp_q.size(), 32'd0);
    check({name, "_level_zero"}, 32'(sel_lvl), 32'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bench UART receiver: samples each bit at its centre on the falling clock edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      rx_active = 1'b0;
      rx_cnt    = 0;
    end else begin
      if (!rx_active) begin
        if (line == 1'b0) begin
          rx_active = 1'b1;
          rx_cnt    = 1;
          if (mark_first) begin
            first_start = cyc;
            mark_first  = 1'b0;
          end
          if (gap_chk && have_prev) check("frame_gap", 32'(cyc - prev_start), 32'(10 * mon_div));
          prev_start = cyc;
          have_prev  = 1'b1;
        end
      end else begin
        rx_cnt++;
      end
      if (rx_active && (rx_cnt % mon_div) == mon_div / 2) begin
        rx_k = rx_cnt / mon_div;
        if (rx_k == 0) begin
          check("rx_start_bit", 32'(line), 32'd0);
        end else if (rx_k <= 8) begin
          rx_shift[rx_k-1] = line;
        end else begin
          check("rx_stop_bit", 32'(line), 32'd1);
          if (exp_q.size() == 0) begin
            check("rx_unexpected_byte", 32'(rx_shift), 32'hFFFF_FFFF);
          end else begin
            rx_exp = exp_q.pop_front();
            check("rx_byte", 32'(rx_shift), 32'(rx_exp));
          end
        end
      end
      if (rx_active && rx_cnt == 10 * mon_div) begin
        rx_active = 1'b0;
        last_end  = cyc;
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] fr;
    logic [4:0] lvl_tab [8];
    int         stalls, max_run, n, low_len, peak;
    string      msg;

    a_if.tx_valid = 1'b0; a_if.tx_data = 8'h00;
    b_if.tx_valid = 1'b0; b_if.tx_data = 8'h00;
    c_if.tx_valid = 1'b0; c_if.tx_data = 8'h00;
    rst_n = 1'b0;
    select(0, 10);

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_uart_tx_a", 32'(a_tx), 32'd1);
    check("rst_tx_ready_a", 32'(a_if.tx_ready), 32'd1);
    check("rst_busy_a", 32'(a_busy), 32'd0);
    check("rst_level_a", 32'(a_lvl), 32'd0);
    check("rst_uart_tx_b", 32'(b_tx), 32'd1);
    check("rst_tx_ready_b", 32'(b_if.tx_ready), 32'd1);
    check("rst_uart_tx_c", 32'(c_tx), 32'd1);
    check("rst_busy_c", 32'(c_busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single 0x55 frame, checked cycle by cycle
    select(0, 10);
    fr = {1'b1, 8'h55, 1'b0};
    drive(1'b1, 8'h55);
    exp_q.push_back(8'h55);
    @(posedge clk); #1;
    drive(1'b0, 8'h00);
    @(negedge clk);
    check("t1_line_before_pop", 32'(line), 32'd1);
    check("t1_level_after_push", 32'(sel_lvl), 32'd1);
    check("t1_busy_after_push", 32'(sel_busy), 32'd1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("t1_line", 32'(line), 32'(fr[i/10]));
      check("t1_busy", 32'(sel_busy), 32'd1);
    end
    @(negedge clk);
    check("t1_busy_at_end", 32'(sel_busy), 32'd0);
    check("t1_line_idle", 32'(line), 32'd1);
    wait_done("t1", 200);

    // 16-byte string back-to-back
    select(0, 10);
    msg = "regs[7]=0x00AB\r\n";
    stim_q.delete();
    for (int i = 0; i < msg.len(); i++) stim_q.push_back(msg[i]);
    have_prev  = 1'b0;
    gap_chk    = 1'b1;
    mark_first = 1'b1;
    send(1'b1, 16, stalls, max_run);
    check("t2_no_ready_drop", 32'(stalls), 32'd0);
    wait_done("t2", 2000);
    gap_chk = 1'b0;
    check("t2_total_cycles", 32'(last_end - first_start + 1), 32'd1600);

    // FIFO_DEPTH=4, eight bytes with tx_valid held
    select(1, 10);
    stim_q.delete();
    for (int i = 1; i <= 8; i++) stim_q.push_back(8'(i));
    send(1'b1, 4, stalls, max_run);
    lvl_tab = '{5'd1, 5'd1, 5'd2, 5'd3, 5'd4, 5'd4, 5'd4, 5'd4};
    peak = 0;
    for (int i = 0; i < lvl_after.size(); i++) begin
      if (i < 8) check("t3_level_after_push", 32'(lvl_after[i]), 32'(lvl_tab[i]));
      if (int'(lvl_after[i]) > peak) peak = int'(lvl_after[i]);
    end
    check("t3_push_count", lvl_after.size(), 32'd8);
    check("t3_peak_level", 32'(peak), 32'd4);
    check("t3_ready_dropped", 32'(stalls > 0), 32'd1);
    check("t3_one_accept_per_pop", 32'(max_run), 32'd1);
    wait_done("t3", 1500);

    // Reset during bit 3 of 0xA5 with three bytes queued
    select(0, 10);
    stim_q.delete();
    stim_q.push_back(8'hA5); stim_q.push_back(8'h11);
    stim_q.push_back(8'h22); stim_q.push_back(8'h33);
    send(1'b0, 16, stalls, max_run);
    n = 0;
    while (!(rx_active && rx_cnt == 45) && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("t5_reached_bit3", 32'(n < 500), 32'd1);
    #2;
    check("t5_bit3_low", 32'(line), 32'd0);
    check("t5_queued", 32'(sel_lvl), 32'd3);
    rst_n = 1'b0;
    #1;
    check("t5_async_uart_tx", 32'(line), 32'd1);
    check("t5_async_level", 32'(sel_lvl), 32'd0);
    check("t5_async_busy", 32'(sel_busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t5_idle_line", 32'(line), 32'd1);
      check("t5_idle_busy", 32'(sel_busy), 32'd0);
    end
    @(posedge clk); #1;
    stim_q.delete();
    stim_q.push_back(8'h3C);
    send(1'b1, 16, stalls, max_run);
    wait_done("t5", 300);

    // Default parameters: DIV=234, 0x0D frame length
    select(2, 234);
    check("t6_uart_div", uart_pkg::uart_div(27_000_000, 115_200), 32'd234);
    mark_first = 1'b1;
    stim_q.delete();
    stim_q.push_back(8'h0D);
    send(1'b1, 16, stalls, max_run);
    n = 0;
    while (line != 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    low_len = 0;
    while (line == 1'b0 && low_len < 1000) begin
      low_len++;
      @(negedge clk);
    end
    check("t6_start_bit_len", 32'(low_len), 32'd234);
    wait_done("t6", 3000);
    check("t6_frame_len", 32'(last_end - first_start + 1), 32'd2340);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte-stream UART transmitter with an input FIFO; sits directly downstream of the register-dump formatter and drives the board's uart_tx pin.
- Accepts bytes over a valid/ready handshake, buffers up to FIFO_DEPTH of them, and serialises each as 8N1, LSB first.
- Replaces the vendor UART master, so the formatter only has to push bytes; no address or enable-pulse sequencing is needed.

Parameters:
- CLK_HZ, 27_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits per second.
- FIFO_DEPTH, 16, byte entries; must be a power of two and at least 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- tx_valid  in  1  upstream has a byte on tx_data.
- tx_data  in  8  byte to transmit.
- tx_ready  out  1  FIFO can accept a byte this cycle.
- uart_tx  out  1  serial line; idles high.
- busy  out  1  a frame is in progress or the FIFO is non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of bytes currently buffered.

Behaviour:
- Decided interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: uart_tx=1, tx_ready=1, busy=0, fifo_level=0. FIFO pointers cleared, state=IDLE, counters=0.
- Divisor: DIV=(CLK_HZ+BAUD/2)/BAUD, integer, rounded to nearest. Defaults give 234. Elaboration fails if DIV<2.
- Handshake and push:
  - tx_ready = !full, combinational from the FIFO count.
  - A push happens on any clock edge where tx_valid && tx_ready. tx_data is written on that edge.
  - tx_valid while full is ignored; no byte is lost or overwritten, and upstream holds it.
- Pop and count:
  - Pop happens on the edge where the serializer leaves IDLE, or leaves STOP with the FIFO non-empty.
  - Pop reads the head byte into a shift register.
  - Push and pop on the same edge leave fifo_level unchanged; this is legal both when full and when non-empty.
  - Pointers wrap modulo FIFO_DEPTH. fifo_level is an explicit counter, 0..FIFO_DEPTH.
- State machine (a single baud counter counts 0..DIV-1 in every state except IDLE):
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop and go to START with counter=0.
  - START: uart_tx=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: uart_tx=shift[0] for DIV cycles per bit. At the end of each bit period, shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: uart_tx=1 for DIV cycles. At the end of the period: if the FIFO is non-empty, pop and go straight to START (frames are contiguous, exactly 10*DIV cycles each); otherwise go to IDLE.
- uart_tx is a registered output, glitch-free.
- Latency: a byte pushed on edge N into an empty FIFO with the serializer IDLE is popped on edge N+1. uart_tx falls after edge N+1, and the frame ends 10*DIV cycles later.
- busy = (state!=IDLE) || (fifo_level!=0).
- Reset mid-frame: uart_tx goes to 1 immediately (asynchronously) and buffered bytes are discarded. After release, the line is idle until a new push.
- A byte being shifted is no longer in the FIFO. It does not count in fifo_level, and a push can refill that slot.

Decomposition:
- Package uart_pkg holds:
  - the tx_state_t enum {IDLE, START, DATA, STOP};
  - the function uart_div(clk_hz, baud) returning the rounded divisor;
  - constants UART_IDLE_LVL=1'b1 and UART_DATA_BITS=8.
- Sub-module sync_fifo (parameterised WIDTH, DEPTH) provides push, pop, full, empty and level.
- The serializer FSM stays in uart_tx_fifo.

Test Plan:
- CLK_HZ=1_000_000, BAUD=100_000 (DIV=10). Push 0x55 once while idle:
  - uart_tx low from 2 edges after the push for 10 cycles;
  - then bits 1,0,1,0,1,0,1,0 for 10 cycles each;
  - stop high for 10 cycles;
  - busy deasserts on the edge the frame ends.
- Same params. Push the 16-byte string "regs[7]=0x00AB\r\n" back-to-back:
  - tx_ready never drops, because the first pop frees a slot;
  - the bench UART receiver decodes the string exactly;
  - inter-frame gap is 0 cycles, total 160*DIV cycles.
- FIFO_DEPTH=4. Hold tx_valid for 8 bytes 0x01..0x08:
  - fifo_level peaks at 4 and tx_ready drops;
  - each pop re-raises tx_ready for exactly one accepting edge;
  - all 8 bytes arrive in order.
- Simultaneous push and pop when full: fifo_level stays 4 and the accepted byte appears last in order.
- Assert rst_n low during bit 3 of a 0xA5 frame with 3 bytes queued:
  - uart_tx=1 immediately; fifo_level=0 and busy=0;
  - after release, push 0x3C and it is transmitted cleanly with no residue of 0xA5.
- Default params: check DIV=234 and a 0x0D frame lasts exactly 2340 cycles.
